// File: rtl/multicycle_control.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback and
// drives datapath strobes, with memory and mul/div wait handshakes, a wait timeout and a sticky trap.
module multicycle_control #(
    parameter bit MULDIV_EN   = 1'b1,
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       md_done,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       md_start,
    output logic       illegal,
    output logic       timeout,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        MD_WAIT   = 4'd3,
        WB_R      = 4'd4,
        EXEC_ADDR = 4'd5,
        MEM_RD    = 4'd6,
        WB_MEM    = 4'd7,
        MEM_WR    = 4'd8,
        EXEC_I    = 4'd9,
        WB_I      = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        TRAP      = 4'd13
    } state_t;

    localparam logic [5:0]  OP_RTYPE = 6'b000000;
    localparam logic [5:0]  OP_LW    = 6'b100011;
    localparam logic [5:0]  OP_SW    = 6'b101011;
    localparam logic [5:0]  OP_ADDI  = 6'b001000;
    localparam logic [5:0]  OP_BEQ   = 6'b000100;
    localparam logic [5:0]  OP_J     = 6'b000010;
    localparam logic [5:0]  FN_MUL   = 6'b011000;
    localparam logic [5:0]  FN_DIV   = 6'b011010;
    localparam logic [31:0] CNT_MAX  = TIMEOUT_MAX;

    state_t               state_reg, state_next;
    logic [TIMEOUT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic                 illegal_reg, illegal_next;
    logic                 timeout_reg, timeout_next;
    logic                 waiting, ready, expired, is_muldiv;

    assign is_muldiv = (funct == FN_MUL) || (funct == FN_DIV);
    assign state     = state_reg;
    assign illegal   = illegal_reg;
    assign timeout   = timeout_reg;

    // The handshake states share one counter; "ready" is whichever signal ends that wait.
    always_comb begin
        waiting = 1'b0;
        ready   = 1'b0;
        case (state_reg)
            FETCH, MEM_RD, MEM_WR: begin
                waiting = 1'b1;
                ready   = mem_ready;
            end
            MD_WAIT: begin
                waiting = 1'b1;
                ready   = md_done;
            end
            default: ;
        endcase
        expired = (TIMEOUT_MAX != 0) && waiting && !ready && (32'(wait_cnt_reg) == CNT_MAX);
    end

    always_comb begin
        state_next   = state_reg;
        illegal_next = illegal_reg;
        timeout_next = timeout_reg;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        md_start     = 1'b0;
        case (state_reg)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_next = EXEC_R;
                    OP_LW, OP_SW: state_next = EXEC_ADDR;
                    OP_ADDI:      state_next = EXEC_I;
                    OP_BEQ:       state_next = BRANCH;
                    OP_J:         state_next = JUMP;
                    default: begin
                        state_next   = TRAP;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                if (!is_muldiv) begin
                    state_next = WB_R;
                end else if (MULDIV_EN) begin
                    md_start   = 1'b1;
                    state_next = MD_WAIT;
                end else begin
                    state_next   = TRAP;
                    illegal_next = 1'b1;
                end
            end
            MD_WAIT: begin
                if (md_done) state_next = WB_R;
            end
            WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = FETCH;
            end
            EXEC_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_next = WB_MEM;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_next = FETCH;
            end
            EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = WB_I;
            end
            WB_I: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_write   = zero;
                state_next = FETCH;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                state_next = FETCH;
            end
            TRAP: ;
            default: state_next = FETCH;
        endcase
        if (expired) begin
            state_next   = TRAP;
            timeout_next = 1'b1;
        end
        // Reset silences the datapath immediately, even mid-instruction.
        if (rst) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            md_start   = 1'b0;
        end
    end

    // Any state change restarts the count, so each wait state starts from zero.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg)
            wait_cnt_next = '0;
        else if (waiting && !ready && (wait_cnt_reg != {TIMEOUT_W{1'b1}}))
            wait_cnt_next = wait_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= FETCH;
            wait_cnt_reg <= '0;
            illegal_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            illegal_reg  <= illegal_next;
            timeout_reg  <= timeout_next;
        end
    end
endmodule
